// File: rtl/acc_shift_seq.sv
// Shift-step sequencer for L/R orders: decodes the step count, aligns to word
// boundaries on the d0 train and emits one enable word per step.
// Optional build macro: ACC_SHIFT_SEQ_ABORT_EN (adds the abort input).
module acc_shift_seq #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d0,
    input  logic              long,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] addr,
`ifdef ACC_SHIFT_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              shift_l,
    output logic              shift_r,
    output logic              done,
    output logic [CNT_W-1:0]  steps
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             parity_q;
    logic             dir_q, dir_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] steps_d;
    logic             busy_d, shift_l_d, shift_r_d, done_d;
    logic [CNT_W-1:0] n_c;
    logic             boundary_c;
    logic             abort_c;

    // Step count is one more than the index of the lowest set address bit.
    function automatic logic [CNT_W-1:0] decode_n(input logic [ADDR_W-1:0] a);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            if (a[i]) n = CNT_W'(i + 1);
        end
        return n;
    endfunction

    assign n_c        = decode_n(addr);
    assign boundary_c = d0 & (~long_q | parity_q);

`ifdef ACC_SHIFT_SEQ_ABORT_EN
    logic abort_pend_q;

    // An abort seen mid-word is held until that word's boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_pend_q <= 1'b0;
        end else begin
            abort_pend_q <= (state_q == SHIFT) && (state_d == SHIFT) && (abort || abort_pend_q);
        end
    end

    assign abort_c = abort | abort_pend_q;
`else
    assign abort_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            parity_q <= 1'b1;
            dir_q    <= 1'b0;
            long_q   <= 1'b0;
            rem_q    <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_q ^ d0;
            dir_q    <= dir_d;
            long_q   <= long_d;
            rem_q    <= rem_d;
            steps    <= steps_d;
            busy     <= busy_d;
            shift_l  <= shift_l_d;
            shift_r  <= shift_r_d;
            done     <= done_d;
        end
    end

    // Next-state and order latching.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        long_d  = long_q;
        rem_d   = rem_q;
        steps_d = steps;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    long_d  = long;
                    rem_d   = n_c;
                    steps_d = n_c;
                    state_d = (n_c == '0) ? DONE : ALIGN;
                end
            end
            ALIGN: begin
                if (abort_c) begin
                    state_d = IDLE;
                end else if (boundary_c) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (boundary_c) begin
                    if (abort_c) begin
                        state_d = IDLE;
                    end else if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values; done trails the DONE state by one clock, busy covers it.
    always_comb begin
        busy_d    = 1'b0;
        shift_l_d = 1'b0;
        shift_r_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != IDLE) || (state_q == DONE);
        shift_l_d = (state_d == SHIFT) && !dir_d;
        shift_r_d = (state_d == SHIFT) && dir_d;
        done_d    = (state_q == DONE);
    end

endmodule

// File: tb/tb_acc_shift_seq.sv
// Scoreboard bench for acc_shift_seq: expected busy/run/done events are queued
// at issue time and a negedge monitor pops and compares observed events.
module tb_acc_shift_seq;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] EV_BUSY = 3'd1;
    localparam logic [2:0] EV_RUN  = 3'd2;
    localparam logic [2:0] EV_DONE = 3'd3;
    localparam logic [2:0] EV_IDLE = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic        dir;
        logic [15:0] cyc;
        logic [15:0] len;
        logic [3:0]  steps;
    } ev_t;

    logic              clk;
    logic              rst_n;
    logic              d0;
    logic              long;
    logic              start;
    logic              dir;
    logic [ADDR_W-1:0] addr;
    logic              abort;
    logic              busy;
    logic              shift_l;
    logic              shift_r;
    logic              done;
    logic [CNT_W-1:0]  steps;

    int  cyc;
    int  n_chk;
    int  n_pass;
    int  overlap;
    ev_t exp_q[$];

    acc_shift_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d0      (d0),
        .long    (long),
        .start   (start),
        .dir     (dir),
        .addr    (addr),
`ifdef ACC_SHIFT_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .shift_l (shift_l),
        .shift_r (shift_r),
        .done    (done),
        .steps   (steps)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and d0 train: d0 is sampled at every edge that is a multiple of 18.
    initial begin
        cyc = 0;
        d0  = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            d0 = (((cyc + 1) % 18) == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [2:0] k, input logic dr, input int c, input int l, input int s);
        ev_t e;
        e.kind  = k;
        e.dir   = dr;
        e.cyc   = 16'(c);
        e.len   = 16'(l);
        e.steps = 4'(s);
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input ev_t act);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got kind=%0d dir=%0d cyc=%0d len=%0d steps=%0d, none expected",
                     act.kind, act.dir, act.cyc, act.len, act.steps);
        end else begin
            e = exp_q.pop_front();
            if (act == e) n_pass++;
            else $display("FAIL sb_event: got kind=%0d dir=%0d cyc=%0d len=%0d steps=%0d expected kind=%0d dir=%0d cyc=%0d len=%0d steps=%0d",
                          act.kind, act.dir, act.cyc, act.len, act.steps,
                          e.kind, e.dir, e.cyc, e.len, e.steps);
        end
    endtask

    // Monitor: turns output waveforms into events, sampled on the falling edge.
    initial begin
        logic prev_en, prev_busy, run_dir;
        int   run_start;
        ev_t  ev;
        prev_en   = 1'b0;
        prev_busy = 1'b0;
        run_dir   = 1'b0;
        run_start = 0;
        overlap   = 0;
        forever begin
            @(negedge clk);
            if (shift_l && shift_r) overlap++;
            if ((shift_l || shift_r) && !prev_en) begin
                run_start = cyc;
                run_dir   = shift_r;
            end
            if (!(shift_l || shift_r) && prev_en) begin
                ev = '{EV_RUN, run_dir, 16'(run_start), 16'(cyc - run_start), 4'd0};
                sb_check(ev);
            end
            if (done === 1'b1) begin
                ev = '{EV_DONE, 1'b0, 16'(cyc), 16'd0, steps};
                sb_check(ev);
            end
            if (busy && !prev_busy) begin
                ev = '{EV_BUSY, 1'b0, 16'(cyc), 16'd0, 4'd0};
                sb_check(ev);
            end
            if (!busy && prev_busy) begin
                ev = '{EV_IDLE, 1'b0, 16'(cyc), 16'd0, 4'd0};
                sb_check(ev);
            end
            prev_en   = shift_l || shift_r;
            prev_busy = busy;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start during cycle 'at'; the DUT accepts it at edge at+1.
    task automatic issue(input int at, input logic l, input logic dr, input logic [ADDR_W-1:0] a);
        wait_cyc(at);
        long  = l;
        dir   = dr;
        addr  = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        long   = 1'b0;
        start  = 1'b0;
        dir    = 1'b0;
        addr   = '0;
        abort  = 1'b0;

        wait_cyc(1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shift_l", 32'(shift_l), 32'd0);
        chk("rst_shift_r", 32'(shift_r), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_steps", 32'(steps), 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;

        // Short R, n=3, started mid minor cycle.
        push(EV_BUSY, 1'b0, 27, 0, 0);
        push(EV_RUN, 1'b1, 36, 54, 0);
        push(EV_DONE, 1'b0, 91, 0, 3);
        push(EV_IDLE, 1'b0, 92, 0, 0);
        issue(26, 1'b0, 1'b1, 11'h004);

        // Long L, n=1, started before a non-boundary d0 (edge 108).
        push(EV_BUSY, 1'b0, 106, 0, 0);
        push(EV_RUN, 1'b0, 126, 36, 0);
        push(EV_DONE, 1'b0, 163, 0, 1);
        push(EV_IDLE, 1'b0, 164, 0, 0);
        issue(105, 1'b1, 1'b0, 11'h001);

        // Zero count goes straight to completion.
        push(EV_BUSY, 1'b0, 171, 0, 0);
        push(EV_DONE, 1'b0, 172, 0, 0);
        push(EV_IDLE, 1'b0, 173, 0, 0);
        issue(170, 1'b0, 1'b1, 11'h000);

        // Higher set bits ignored; second start in SHIFT ignored.
        push(EV_BUSY, 1'b0, 181, 0, 0);
        push(EV_RUN, 1'b0, 198, 18, 0);
        push(EV_DONE, 1'b0, 217, 0, 1);
        push(EV_IDLE, 1'b0, 218, 0, 0);
        issue(180, 1'b0, 1'b0, 11'h401);
        issue(205, 1'b1, 1'b1, 11'h000);

        // Reset mid-SHIFT of n=11: outputs clear at once, no done.
        push(EV_BUSY, 1'b0, 231, 0, 0);
        push(EV_RUN, 1'b1, 234, 26, 0);
        push(EV_IDLE, 1'b0, 260, 0, 0);
        issue(230, 1'b0, 1'b1, 11'h400);
        wait_cyc(260);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_shift_r", 32'(shift_r), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_steps", 32'(steps), 32'd0);
        wait_cyc(272);
        rst_n = 1'b1;

        // First d0 after reset (edge 288) must act as a long-word boundary.
        push(EV_BUSY, 1'b0, 276, 0, 0);
        push(EV_RUN, 1'b0, 288, 72, 0);
        push(EV_DONE, 1'b0, 361, 0, 2);
        push(EV_IDLE, 1'b0, 362, 0, 0);
        issue(275, 1'b1, 1'b0, 11'h002);

`ifdef ACC_SHIFT_SEQ_ABORT_EN
        // Abort during step 2 of n=4 ends at the step-2 boundary.
        push(EV_BUSY, 1'b0, 371, 0, 0);
        push(EV_RUN, 1'b1, 378, 36, 0);
        push(EV_IDLE, 1'b0, 414, 0, 0);
        issue(370, 1'b0, 1'b1, 11'h008);
        wait_cyc(400);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;

        // Abort while aligning returns to idle on the next clock.
        push(EV_BUSY, 1'b0, 421, 0, 0);
        push(EV_IDLE, 1'b0, 426, 0, 0);
        issue(420, 1'b0, 1'b0, 11'h001);
        wait_cyc(425);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
`endif

        wait_cyc(450);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        chk("en_overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
